// File: rtl/abr_sha3_squeeze.sv
// Squeeze reader: streams the Keccak rate as 64-bit words and requests permutations until out_len words are sent.
// Optional ABR_SHA3_SQUEEZE_ZEROIZE_EN blanks digest_data_o outside valid beats.
module abr_sha3_squeeze #(
  parameter int StateW   = 1600,
  parameter int MsgWidth = 64,
  parameter int OutLenW  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [2:0]          strength_i,
  input  logic [OutLenW-1:0]  out_len_i,
  input  logic                abort_i,
  input  logic                state_valid_i,
  input  logic [StateW-1:0]   state_i,
  output logic                run_o,
  output logic                digest_valid_o,
  output logic [MsgWidth-1:0] digest_data_o,
  output logic                digest_last_o,
  input  logic                digest_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int NumWords = StateW / MsgWidth;
  localparam int IdxW     = $clog2(NumWords);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StStream
  } st_e;

  st_e                 st_q, st_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [OutLenW-1:0]  rem_q, rem_d;
  logic [2:0]          str_q, str_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hs;
  logic [MsgWidth-1:0] word_sel;

  // Index of the final rate word for each strength (rate - 1).
  function automatic logic [IdxW-1:0] rate_last(input logic [2:0] s);
    case (s)
      3'd0:    rate_last = IdxW'(20);
      3'd1:    rate_last = IdxW'(17);
      3'd2:    rate_last = IdxW'(16);
      3'd3:    rate_last = IdxW'(12);
      3'd4:    rate_last = IdxW'(8);
      default: rate_last = IdxW'(20);
    endcase
  endfunction

  assign hs = digest_valid_o & digest_ready_i;

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    rem_d  = rem_q;
    str_d  = str_q;
    run_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (abort_i) begin
      st_d  = StIdle;
      idx_d = '0;
      rem_d = '0;
    end else begin
      if (start_i) begin
        if (st_q != StIdle || strength_i > 3'd4) begin
          err_d = 1'b1;
        end else if (out_len_i == '0) begin
          done_d = 1'b1;
        end else begin
          str_d = strength_i;
          rem_d = out_len_i;
          idx_d = '0;
          st_d  = StWait;
        end
      end
      case (st_q)
        StWait: begin
          if (state_valid_i) st_d = StStream;
        end
        StStream: begin
          if (hs) begin
            rem_d = rem_q - OutLenW'(1);
            // Completion outranks the rate boundary: no permutation after the last word.
            if (rem_q == OutLenW'(1)) begin
              done_d = 1'b1;
              idx_d  = '0;
              st_d   = StIdle;
            end else if (idx_q == rate_last(str_q)) begin
              idx_d = '0;
              run_d = 1'b1;
              st_d  = StWait;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= StIdle;
      idx_q  <= '0;
      rem_q  <= '0;
      str_q  <= 3'd0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      rem_q  <= rem_d;
      str_q  <= str_d;
      run_q  <= run_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign word_sel       = state_i[MsgWidth*int'(idx_q) +: MsgWidth];
  assign digest_valid_o = (st_q == StStream);
  assign digest_last_o  = digest_valid_o && (rem_q == OutLenW'(1));
  assign busy_o         = (st_q != StIdle);
  assign run_o          = run_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

`ifdef ABR_SHA3_SQUEEZE_ZEROIZE_EN
  assign digest_data_o = digest_valid_o ? word_sel : '0;
`else
  assign digest_data_o = word_sel;
`endif

endmodule

// File: tb/tb_abr_sha3_squeeze.sv
// Bench for abr_sha3_squeeze: expected beats are queued per request and matched on each handshake.
// Honours ABR_SHA3_SQUEEZE_ZEROIZE_EN for the idle/wait data view.
module tb_abr_sha3_squeeze;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [2:0]   strength_i;
  logic [15:0]  out_len_i;
  logic         abort_i;
  logic         state_valid_i;
  logic [1599:0] state_i;
  logic         run_o;
  logic         digest_valid_o;
  logic [63:0]  digest_data_o;
  logic         digest_last_o;
  logic         digest_ready_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int n_chk  = 0;
  int n_pass = 0;
  int beat_cnt = 0, run_cnt = 0, done_cnt = 0, err_cnt = 0;
  int ready_mode = 0;
  int seed_next = 0;
  logic [64:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  abr_sha3_squeeze dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .strength_i(strength_i),
    .out_len_i(out_len_i), .abort_i(abort_i), .state_valid_i(state_valid_i),
    .state_i(state_i), .run_o(run_o), .digest_valid_o(digest_valid_o),
    .digest_data_o(digest_data_o), .digest_last_o(digest_last_o),
    .digest_ready_i(digest_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  function automatic logic [63:0] wd(input int seed, input int w);
    return {32'(seed) ^ 32'hA5A5_0000, 32'(w) * 32'h9E37_79B1 + 32'(seed)};
  endfunction

  function automatic logic [1599:0] mk_state(input int seed);
    logic [1599:0] s;
    for (int w = 0; w < 25; w++) s[64*w +: 64] = wd(seed, w);
    return s;
  endfunction

  function automatic int rate_of(input int s);
    case (s)
      0: return 21;
      1: return 18;
      2: return 17;
      3: return 13;
      default: return 9;
    endcase
  endfunction

  // Scoreboard side: one entry per expected beat, block b of the request uses state seed+b.
  task automatic push_expected(input int strength, input int len, input int seed);
    int r;
    r = rate_of(strength);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), wd(seed + i / r, i % r)});
  endtask

  // Monitor: handshakes, data stability under backpressure, pulse widths.
  logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_run = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  logic [64:0] prev_beat;
  always @(negedge clk_i) begin
    logic [64:0] e;
    if (rst_ni === 1'b1) begin
      if (prev_vld && !prev_rdy && digest_valid_o === 1'b1) begin
        n_chk++;
        if ({digest_last_o, digest_data_o} !== prev_beat)
          $display("FAIL stall_stable got %h want %h", {digest_last_o, digest_data_o}, prev_beat);
        else n_pass++;
      end
      if (digest_valid_o === 1'b1 && digest_ready_i && !abort_i) begin
        beat_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected got %h want none", {digest_last_o, digest_data_o});
        end else begin
          e = exp_q.pop_front();
          if ({digest_last_o, digest_data_o} !== e)
            $display("FAIL beat_data got %h want %h", {digest_last_o, digest_data_o}, e);
          else n_pass++;
        end
      end
      if (run_o === 1'b1) run_cnt++;
      if (done_o === 1'b1) done_cnt++;
      if (err_o === 1'b1) err_cnt++;
      if ((run_o === 1'b1 && prev_run) || (done_o === 1'b1 && prev_done) || (err_o === 1'b1 && prev_err)) begin
        n_chk++;
        $display("FAIL pulse_width got run/done/err held %b%b%b want single-cycle", run_o, done_o, err_o);
      end
    end
    prev_vld  = (digest_valid_o === 1'b1);
    prev_rdy  = digest_ready_i;
    prev_beat = {digest_last_o, digest_data_o};
    prev_run  = (run_o === 1'b1);
    prev_done = (done_o === 1'b1);
    prev_err  = (err_o === 1'b1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic begin_req(input int strength, input int len, input int seed);
    start_i    = 1'b1;
    strength_i = 3'(strength);
    out_len_i  = 16'(len);
    tick();
    start_i = 1'b0;
    tick();
    tick();
    state_i       = mk_state(seed);
    state_valid_i = 1'b1;
    tick();
    state_valid_i = 1'b0;
  endtask

  // Plays the Keccak core: answers each run_o with the next state two cycles later.
  task automatic serve(input int seed, input int max_cycles);
    int pend = 0;
    int blk  = 1;
    for (int c = 0; c < max_cycles; c++) begin
      digest_ready_i = (ready_mode == 0) ? 1'b1 : ((c % 2) == 0);
      tick();
      state_valid_i = 1'b0;
      if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          state_i       = mk_state(seed + blk);
          state_valid_i = 1'b1;
          blk++;
        end
      end
      if (run_o === 1'b1) pend = 2;
      if (done_o === 1'b1) break;
    end
    state_valid_i  = 1'b0;
    digest_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    state_i = '0;
    repeat (3) tick();
    n_chk++;
    if ({digest_valid_o, digest_last_o, busy_o, run_o, done_o, err_o, digest_data_o} !== 70'd0)
      $display("FAIL reset_outputs got %h want 0", {digest_valid_o, digest_last_o, busy_o, run_o, done_o, err_o, digest_data_o});
    else n_pass++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_l256_basic();
    int d0 = done_cnt, r0 = run_cnt, b0 = beat_cnt;
    int seed = seed_next;
    seed_next += 10;
    push_expected(2, 4, seed);
    begin_req(2, 4, seed);
    n_chk++;
    if (digest_valid_o !== 1'b1) $display("FAIL l256_valid_after_state got %b want 1", digest_valid_o);
    else n_pass++;
    serve(seed, 100);
    tick();
    n_chk++;
    if (done_cnt - d0 != 1 || run_cnt != r0 || beat_cnt - b0 != 4)
      $display("FAIL l256_counts got done=%0d run=%0d beats=%0d want 1/0/4", done_cnt - d0, run_cnt - r0, beat_cnt - b0);
    else n_pass++;
    n_chk++;
    if (busy_o !== 1'b0 || exp_q.size() != 0)
      $display("FAIL l256_end got busy=%b left=%0d want 0/0", busy_o, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_l128_22();
    int d0 = done_cnt, r0 = run_cnt, b0 = beat_cnt;
    int seed = seed_next;
    seed_next += 10;
    push_expected(0, 22, seed);
    begin_req(0, 22, seed);
    serve(seed, 200);
    tick();
    n_chk++;
    if (done_cnt - d0 != 1 || run_cnt - r0 != 1 || beat_cnt - b0 != 22 || exp_q.size() != 0)
      $display("FAIL l128_counts got done=%0d run=%0d beats=%0d want 1/1/22", done_cnt - d0, run_cnt - r0, beat_cnt - b0);
    else n_pass++;
  endtask

  task automatic test_l512_toggle();
    int d0 = done_cnt, r0 = run_cnt, b0 = beat_cnt;
    int seed = seed_next;
    seed_next += 10;
    push_expected(4, 20, seed);
    ready_mode = 1;
    begin_req(4, 20, seed);
    serve(seed, 400);
    ready_mode = 0;
    tick();
    n_chk++;
    if (done_cnt - d0 != 1 || run_cnt - r0 != 2 || beat_cnt - b0 != 20 || exp_q.size() != 0)
      $display("FAIL l512_counts got done=%0d run=%0d beats=%0d want 1/2/20", done_cnt - d0, run_cnt - r0, beat_cnt - b0);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int b0 = beat_cnt;
    start_i = 1'b1; strength_i = 3'd2; out_len_i = 16'd0;
    tick();
    start_i = 1'b0;
    n_chk++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || digest_valid_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL zero_len got done=%b busy=%b vld=%b err=%b want 1/0/0/0", done_o, busy_o, digest_valid_o, err_o);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (beat_cnt != b0 || busy_o !== 1'b0) $display("FAIL zero_len_quiet got beats=%0d busy=%b want 0/0", beat_cnt - b0, busy_o);
    else n_pass++;
  endtask

  task automatic test_bad_strength();
    start_i = 1'b1; strength_i = 3'b101; out_len_i = 16'd4;
    tick();
    start_i = 1'b0;
    n_chk++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL bad_strength got err=%b busy=%b done=%b want 1/0/0", err_o, busy_o, done_o);
    else n_pass++;
    tick();
    n_chk++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) $display("FAIL bad_strength_after got busy=%b err=%b want 0/0", busy_o, err_o);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    int d0 = done_cnt, b0 = beat_cnt;
    int seed = seed_next;
    seed_next += 10;
    push_expected(2, 6, seed);
    begin_req(2, 6, seed);
    tick();
    tick();
    start_i = 1'b1; strength_i = 3'd4; out_len_i = 16'd1;
    tick();
    start_i = 1'b0;
    n_chk++;
    if (err_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL start_busy_err got err=%b busy=%b want 1/1", err_o, busy_o);
    else n_pass++;
    serve(seed, 100);
    tick();
    n_chk++;
    if (done_cnt - d0 != 1 || beat_cnt - b0 != 6 || exp_q.size() != 0)
      $display("FAIL start_busy_stream got done=%0d beats=%0d want 1/6", done_cnt - d0, beat_cnt - b0);
    else n_pass++;
  endtask

  task automatic test_abort();
    int d0, b0 = beat_cnt;
    int seed = seed_next;
    seed_next += 10;
    push_expected(2, 10, seed);
    begin_req(2, 10, seed);
    for (int c = 0; c < 50 && beat_cnt - b0 < 4; c++) tick();
    d0 = done_cnt;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_chk++;
    if (digest_valid_o !== 1'b0 || busy_o !== 1'b0 || beat_cnt - b0 != 4)
      $display("FAIL abort_stop got vld=%b busy=%b beats=%0d want 0/0/4", digest_valid_o, busy_o, beat_cnt - b0);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (done_cnt != d0) $display("FAIL abort_no_done got %0d want 0", done_cnt - d0);
    else n_pass++;
    exp_q.delete();
    seed = seed_next;
    seed_next += 10;
    d0 = done_cnt;
    push_expected(2, 3, seed);
    begin_req(2, 3, seed);
    serve(seed, 100);
    tick();
    n_chk++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0)
      $display("FAIL abort_restart got done=%0d left=%0d want 1/0", done_cnt - d0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wait_view();
    logic [63:0] want;
    int seed = seed_next;
    seed_next += 10;
    state_i = mk_state(seed);
    start_i = 1'b1; strength_i = 3'd3; out_len_i = 16'd2;
    tick();
    start_i = 1'b0;
    tick();
`ifdef ABR_SHA3_SQUEEZE_ZEROIZE_EN
    want = 64'd0;
`else
    want = wd(seed, 0);
`endif
    n_chk++;
    if (busy_o !== 1'b1 || digest_valid_o !== 1'b0 || digest_data_o !== want)
      $display("FAIL wait_view got busy=%b vld=%b data=%h want 1/0/%h", busy_o, digest_valid_o, digest_data_o, want);
    else n_pass++;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_chk++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL wait_abort got busy=%b done=%b want 0/0", busy_o, done_o);
    else n_pass++;
  endtask

  initial begin
    start_i = 1'b0; strength_i = 3'd0; out_len_i = 16'd0; abort_i = 1'b0;
    state_valid_i = 1'b0; digest_ready_i = 1'b1; state_i = '0; rst_ni = 1'b0;
    test_reset();
    test_l256_basic();
    test_l128_22();
    test_l512_toggle();
    test_zero_len();
    test_bad_strength();
    test_start_busy();
    test_abort();
    test_wait_view();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
